// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LDPC encoder types, defaults and helpers
package ldpc_pkg;

    localparam int LDPC_N = 6;
    localparam int LDPC_K = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_e;

    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/ldpc_enc_ctrl_if.sv
// rtl/ldpc_enc_ctrl_if.sv - config, info-in and codeword-out signal bundle
interface ldpc_enc_ctrl_if #(
    parameter int N = ldpc_pkg::LDPC_N,
    parameter int K = ldpc_pkg::LDPC_K
);
    localparam int CW = ldpc_pkg::clog2_min1(K);

    logic            cfg_we;
    logic [CW-1:0]   cfg_addr;
    logic [N-K-1:0]  cfg_data;
    logic            cfg_ready;
    logic            in_valid;
    logic            in_ready;
    logic [K-1:0]    in_info;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_codeword;
    logic            busy;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_info, out_ready,
        input  cfg_ready, in_ready, out_valid, out_codeword, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_info, out_ready,
        output cfg_ready, in_ready, out_valid, out_codeword, busy
    );
endinterface

// File: rtl/ldpc_p_rowmem.sv
// rtl/ldpc_p_rowmem.sv - K x (N-K) parity sub-matrix storage
module ldpc_p_rowmem #(
    parameter int N  = ldpc_pkg::LDPC_N,
    parameter int K  = ldpc_pkg::LDPC_K,
    parameter int CW = ldpc_pkg::clog2_min1(K)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we_i,
    input  logic [CW-1:0]  wr_addr_i,
    input  logic [N-K-1:0] wr_data_i,
    input  logic [CW-1:0]  rd_addr_i,
    output logic [N-K-1:0] rd_data_o
);
    logic [N-K-1:0] mem_q [K];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (int'(wr_addr_i) < K)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read index is the row counter, which never leaves 0..K-1.
    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/ldpc_enc_ctrl.sv
// rtl/ldpc_enc_ctrl.sv - bit-serial systematic LDPC encoder sequencer
module ldpc_enc_ctrl
    import ldpc_pkg::*;
#(
    parameter int N = LDPC_N,
    parameter int K = LDPC_K
) (
    input logic            clk,
    input logic            rst_n,
    ldpc_enc_ctrl_if.slave bus
);
    localparam int CW = clog2_min1(K);

    state_e         state_q, state_d;
    logic [K-1:0]   info_q, info_d;
    logic [N-K-1:0] parity_q, parity_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-K-1:0] row_rd;
    logic           row_we;

    // Same-cycle write and accept: the row lands at this edge, ACCUM reads it later.
    assign row_we = bus.cfg_we && (state_q == IDLE);

    ldpc_p_rowmem #(.N(N), .K(K), .CW(CW)) u_rowmem (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (row_we),
        .wr_addr_i (bus.cfg_addr),
        .wr_data_i (bus.cfg_data),
        .rd_addr_i (cnt_q),
        .rd_data_o (row_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            info_q   <= '0;
            parity_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            info_q   <= info_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        info_d   = info_q;
        parity_d = parity_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    info_d   = bus.in_info;
                    parity_d = '0;
                    cnt_d    = '0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (info_q[cnt_q]) begin
                    parity_d = parity_q ^ row_rd;
                end
                if (cnt_q == CW'(K - 1)) begin
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All outputs come from registers only.
    assign bus.in_ready     = (state_q == IDLE);
    assign bus.cfg_ready    = (state_q == IDLE);
    assign bus.out_valid    = (state_q == OUT);
    assign bus.busy         = (state_q != IDLE);
    assign bus.out_codeword = {parity_q, info_q};
endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// tb/tb_ldpc_enc_ctrl.sv - directed self-checking bench for ldpc_enc_ctrl
module tb_ldpc_enc_ctrl;
    localparam int N  = 6;
    localparam int K  = 3;
    localparam int CW = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ldpc_enc_ctrl_if #(.N(N), .K(K)) bus ();

    ldpc_enc_ctrl #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-K-1:0] tb_p [K];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_cw(input logic [K-1:0] info);
        logic [N-K-1:0] par;
        par = '0;
        for (int i = 0; i < K; i++) begin
            if (info[i]) par = par ^ tb_p[i];
        end
        return {par, info};
    endfunction

    task automatic cfg_write(input logic [CW-1:0] addr, input logic [N-K-1:0] data);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    // Sends one word with out_ready high; optionally issues a cfg write in the accept cycle.
    task automatic run_word(input string tag, input logic [K-1:0] info, input logic [N-1:0] exp,
                            input bit with_cfg, input logic [CW-1:0] addr, input logic [N-K-1:0] data);
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_info  = info;
        if (with_cfg) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = addr;
            bus.cfg_data = data;
        end
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'(K));
        check({tag, "_cw"}, 32'(bus.out_codeword), 32'(exp));
        @(posedge clk);
        #1;
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    logic [K-1:0] words [20];

    initial begin
        logic [N-1:0] held;
        int lat;
        int sent, got, last_acc, cyc;
        bit acc_now, out_fire;

        total = 0;
        bad   = 0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.in_valid  = 1'b0;
        bus.in_info   = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_cw", 32'(bus.out_codeword), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        cfg_write(2'd0, 3'b011);
        cfg_write(2'd1, 3'b101);
        cfg_write(2'd2, 3'b110);
        run_word("w010", 3'b010, 6'h2A, 1'b0, '0, '0);
        run_word("w111", 3'b111, 6'h07, 1'b0, '0, '0);
        run_word("w011", 3'b011, 6'h33, 1'b0, '0, '0);

        // Backpressure hold with a config write attempted during ACCUM.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_info   = 3'b011;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'd1;
        bus.cfg_data = 3'b000;
        check("accum_busy", 32'(bus.busy), 32'd1);
        check("accum_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) break;
        end
        check("hold_latency", 32'(lat), 32'd3);
        held = bus.out_codeword;
        check("hold_cw", 32'(held), 32'h33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_stable", 32'(bus.out_codeword), 32'(held));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        end
        bus.cfg_we    = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release", 32'(bus.out_valid), 32'd0);
        run_word("ignored_cfg", 3'b010, 6'h2A, 1'b0, '0, '0);

        run_word("same_cycle", 3'b010, 6'h3A, 1'b1, 2'd1, 3'b111);
        cfg_write(2'd3, 3'b001);
        run_word("addr3_ignored", 3'b111, 6'h17, 1'b0, '0, '0);

        // Reset in the middle of ACCUM drops the word and clears P.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_info  = 3'b111;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_cw", 32'(bus.out_codeword), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_word("p_cleared", 3'b101, 6'h05, 1'b0, '0, '0);

        tb_p[0] = 3'b011;
        tb_p[1] = 3'b101;
        tb_p[2] = 3'b110;
        for (int i = 0; i < K; i++) cfg_write(CW'(i), tb_p[i]);
        for (int i = 0; i < 20; i++) words[i] = K'($urandom_range(0, 7));

        sent = 0;
        got = 0;
        last_acc = 0;
        cyc = 0;
        while (cyc < 300 && got < 20) begin
            @(negedge clk);
            if (sent < 20) begin
                bus.in_valid = 1'b1;
                bus.in_info  = words[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            acc_now  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            if (out_fire) begin
                check("b2b_cw", 32'(bus.out_codeword), 32'(ref_cw(words[got])));
                got++;
            end
            if (acc_now) begin
                if (sent > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'(K + 2));
                last_acc = cyc;
                sent++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("b2b_count", 32'(got), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ldpc_enc_ctrl.md
Name: ldpc_enc_ctrl

Overview:
- Sequencing controller for the systematic LDPC encoder datapath.
- Holds the K x (N-K) parity sub-matrix P, loaded row by row over a config port.
- Accepts K-bit info words over a valid/ready handshake and computes parity bit-serially, one P row per cycle.
- Emits the N-bit systematic codeword over a valid/ready handshake. It sits between the info-bit source and the modulator/channel-model stage.

Parameters:
N, 6, codeword length in bits
K, 3, info length in bits; require 1 <= K < N
CW, $clog2(K) (min 1), row counter / row address width (localparam)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous, active-low reset
cfg_we  input  1  P-row write strobe
cfg_addr  input  CW  P row index i
cfg_data  input  N-K  row i of P; bit j = P[i][j]
cfg_ready  output  1  high when a config write will be accepted (state IDLE)
in_valid  input  1  info word present
in_ready  output  1  controller can take an info word
in_info  input  K  info bits; bit i multiplies row i
out_valid  output  1  codeword available
out_ready  input  1  sink accepts codeword
out_codeword  output  N  [K-1:0]=info, [N-1:K]=parity
busy  output  1  high in ACCUM or OUT

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All P storage, info register, parity accumulator and row counter clear to 0.
  - Outputs: out_valid=0, out_codeword=0, busy=0, in_ready=1, cfg_ready=1.
  - Reset wins over every other input, including mid-ACCUM and mid-OUT; any in-flight word is dropped.
- IDLE:
  - in_ready=1, cfg_ready=1.
  - cfg_we=1 with cfg_addr<K writes P[cfg_addr] at the edge. cfg_addr>=K is ignored.
  - in_valid=1 latches in_info, clears parity, sets cnt=0 and moves to ACCUM.
  - cfg_we and in_valid in the same cycle: both take effect. The row write lands first, so the new row is used by this word.
- ACCUM, one cycle per row:
  - parity <= parity ^ (info[cnt] ? P[cnt] : 0).
  - cnt increments. After processing row K-1, move to OUT.
  - in_ready=0, cfg_ready=0; cfg_we is ignored.
- OUT:
  - out_valid=1; out_codeword={parity, info} is registered and stable while out_valid=1.
  - out_valid&&out_ready moves to IDLE; out_valid drops next cycle.
  - out_ready low means hold indefinitely.
- Latency:
  - Input handshake at edge t means out_valid is first seen high after edge t+K.
  - Throughput is one word per K+2 cycles when the sink is always ready (OUT and IDLE each cost one cycle).
  - No combinational path from in_valid or out_ready to any output.
- Arithmetic: GF(2) only; parity width N-K; no overflow cases.
- Zero cases: all-zero info gives zero parity. All-zero P gives codeword {0, info}.
- Counter wrap: cnt never exceeds K-1. For K=1, ACCUM lasts exactly one cycle.

Decomposition:
- Package ldpc_pkg:
  - state enum {IDLE, ACCUM, OUT}.
  - Function clog2_min1.
  - Default N/K constants shared with the encoder datapath.
- Sub-module ldpc_p_rowmem:
  - K x (N-K) register array with synchronous write and asynchronous row read, cleared on rst_n.
  - Instantiated once. FSM, counter and accumulator stay in ldpc_enc_ctrl.

Test Plan (N=6, K=3; P rows: P0=3'b011, P1=3'b101, P2=3'b110):
- Reset, then load the three rows; send info=3'b010 -> out_valid high 3 edges after the accept, codeword=6'b101_010 (0x2A).
- info=3'b111 -> parity 011^101^110=000, codeword=0x07. info=3'b011 -> codeword=6'b110_011 (0x33).
- Hold out_ready=0 for 5 cycles during OUT -> codeword stable, in_ready=0, cfg_ready=0. A cfg_we to row 1 with 3'b000 in ACCUM/OUT is ignored; the next info=3'b010 still gives 0x2A.
- In IDLE, cfg_we row1=3'b111 in the same cycle as in_valid info=3'b010 -> codeword=6'b111_010 (0x3A). A write to cfg_addr=3 is ignored.
- Assert rst_n=0 for one cycle mid-ACCUM -> out_valid=0, in_ready=1 next cycle, P cleared. info=3'b101 then gives codeword=0x05.
- Back-to-back words with out_ready tied 1 -> accepts spaced exactly K+2=5 cycles apart, no lost or duplicated words over 20 random info words, all matching a reference model.
